// File: rtl/target_lut_rw.sv
// Small read/write target lookup table with registered read port and a
// multi-cycle fill sequence that loads INIT_VAL into every entry.
module target_lut_rw #(
    parameter int                ADDR_W   = 2,
    parameter int                TGT_W    = 10,
    parameter logic [TGT_W-1:0]  INIT_VAL = 10'h3FF
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              Init,
    input  logic              RdEn,
    input  logic [ADDR_W-1:0] Addr,
    input  logic              WrEn,
    input  logic [ADDR_W-1:0] WrAddr,
    input  logic [TGT_W-1:0]  WrData,
    output logic [TGT_W-1:0]  Target,
    output logic              Valid,
    output logic              Busy,
    output logic              WrErr
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        FILL = 1'b1
    } state_t;

    state_t              state_r;
    state_t              state_s;
    logic [ADDR_W-1:0]   fill_idx_r;
    logic [ADDR_W-1:0]   fill_idx_s;
    logic [TGT_W-1:0]    lut_r [DEPTH];
    logic [TGT_W-1:0]    target_r;
    logic                valid_r;
    logic                wr_err_r;
    logic                rd_ok_s;
    logic                wr_ok_s;
    logic                wr_err_s;
    logic [TGT_W-1:0]    rd_data_s;

    // Access qualification and write-first read data selection.
    always_comb begin
        rd_ok_s   = RdEn && (state_r == IDLE) && !Init;
        wr_ok_s   = WrEn && (state_r == IDLE) && !Init;
        wr_err_s  = WrEn && ((state_r == FILL) || Init);
        rd_data_s = lut_r[Addr];
        if (wr_ok_s && (WrAddr == Addr)) begin
            rd_data_s = WrData;
        end else begin
            rd_data_s = lut_r[Addr];
        end
    end

    // Next-state logic for the fill sequencer.
    always_comb begin
        state_s    = state_r;
        fill_idx_s = fill_idx_r;
        case (state_r)
            IDLE: begin
                if (Init) begin
                    state_s    = FILL;
                    fill_idx_s = '0;
                end else begin
                    state_s    = IDLE;
                    fill_idx_s = fill_idx_r;
                end
            end
            FILL: begin
                if (Init) begin
                    state_s    = FILL;
                    fill_idx_s = '0;
                end else if (fill_idx_r == LAST_IDX) begin
                    state_s    = IDLE;
                    fill_idx_s = '0;
                end else begin
                    state_s    = FILL;
                    fill_idx_s = fill_idx_r + ADDR_W'(1);
                end
            end
            default: begin
                state_s    = FILL;
                fill_idx_s = '0;
            end
        endcase
    end

    // Sequencer state and registered outputs; reset starts a fresh fill.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_r    <= FILL;
            fill_idx_r <= '0;
            target_r   <= '0;
            valid_r    <= 1'b0;
            wr_err_r   <= 1'b0;
        end else begin
            state_r    <= state_s;
            fill_idx_r <= fill_idx_s;
            valid_r    <= rd_ok_s;
            wr_err_r   <= wr_err_s;
            if (rd_ok_s) begin
                target_r <= rd_data_s;
            end else begin
                target_r <= target_r;
            end
        end
    end

    // Table storage: contents are only defined once a fill has completed.
    always_ff @(posedge Clk) begin
        if (state_r == FILL) begin
            lut_r[fill_idx_r] <= INIT_VAL;
        end else if (wr_ok_s) begin
            lut_r[WrAddr] <= WrData;
        end
    end

    assign Target = target_r;
    assign Valid  = valid_r;
    assign Busy   = (state_r == FILL);
    assign WrErr  = wr_err_r;

endmodule

// File: tb/tb_target_lut_rw.sv
// Randomised and directed bench for target_lut_rw against a cycle-level
// reference model (remaining-fill counter plus an array of entries).
module tb_target_lut_rw;

    localparam int ADDR_W = 2;
    localparam int TGT_W  = 10;
    localparam int DEPTH  = 4;
    localparam logic [TGT_W-1:0] INIT_VAL = 10'h3FF;

    logic              Clk;
    logic              Reset_n;
    logic              Init;
    logic              RdEn;
    logic [ADDR_W-1:0] Addr;
    logic              WrEn;
    logic [ADDR_W-1:0] WrAddr;
    logic [TGT_W-1:0]  WrData;
    logic [TGT_W-1:0]  Target;
    logic              Valid;
    logic              Busy;
    logic              WrErr;

    int n_checks;
    int n_errors;

    // reference model state
    logic [TGT_W-1:0] mem_m [DEPTH];
    int               fill_left_m;
    logic [TGT_W-1:0] target_m;
    logic             valid_m;
    logic             wrerr_m;

    target_lut_rw #(.ADDR_W(ADDR_W), .TGT_W(TGT_W), .INIT_VAL(INIT_VAL)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .Init(Init), .RdEn(RdEn), .Addr(Addr),
        .WrEn(WrEn), .WrAddr(WrAddr), .WrData(WrData), .Target(Target),
        .Valid(Valid), .Busy(Busy), .WrErr(WrErr)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        fill_left_m = DEPTH;
        target_m    = '0;
        valid_m     = 1'b0;
        wrerr_m     = 1'b0;
    endtask

    // One clock edge of the reference model, from the inputs present at the edge.
    task automatic model_edge(input logic init, input logic rd, input logic [ADDR_W-1:0] a,
                              input logic wr, input logic [ADDR_W-1:0] wa,
                              input logic [TGT_W-1:0] wd);
        bit busy;
        bit rd_acc;
        bit wr_acc;
        busy   = (fill_left_m > 0);
        rd_acc = rd && !busy && !init;
        wr_acc = wr && !busy && !init;
        wrerr_m = wr && (busy || init);
        valid_m = rd_acc;
        if (rd_acc) target_m = (wr_acc && wa == a) ? wd : mem_m[a];
        if (wr_acc) mem_m[wa] = wd;
        if (init) begin
            fill_left_m = DEPTH;
        end else if (fill_left_m > 0) begin
            fill_left_m--;
            if (fill_left_m == 0) begin
                for (int i = 0; i < DEPTH; i++) mem_m[i] = INIT_VAL;
            end
        end
    endtask

    task automatic compare_all(input string tag);
        check({tag, ".target"}, 32'(Target), 32'(target_m));
        check({tag, ".valid"},  32'(Valid),  32'(valid_m));
        check({tag, ".busy"},   32'(Busy),   32'(fill_left_m > 0));
        check({tag, ".wrerr"},  32'(WrErr),  32'(wrerr_m));
    endtask

    // Apply inputs (called just after a falling edge), clock once, compare.
    task automatic step(input string tag, input logic init, input logic rd,
                        input logic [ADDR_W-1:0] a, input logic wr,
                        input logic [ADDR_W-1:0] wa, input logic [TGT_W-1:0] wd);
        Init = init; RdEn = rd; Addr = a; WrEn = wr; WrAddr = wa; WrData = wd;
        @(posedge Clk);
        model_edge(init, rd, a, wr, wa, wd);
        #1;
        compare_all(tag);
        @(negedge Clk);
    endtask

    task automatic idle(input string tag);
        step(tag, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 10'h000);
    endtask

    // Idle until Busy drops, checking the fill length.
    task automatic count_fill(input string tag, input int expected);
        int n;
        n = 0;
        while (Busy && n < 20) begin
            idle(tag);
            n++;
        end
        check({tag, ".fill_len"}, 32'(n), 32'(expected));
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        for (int i = 0; i < DEPTH; i++) mem_m[i] = INIT_VAL;
        Reset_n = 1'b0; Init = 1'b0; RdEn = 1'b0; Addr = '0;
        WrEn = 1'b0; WrAddr = '0; WrData = '0;
        model_reset();
        @(negedge Clk);
        @(negedge Clk);
        compare_all("reset");
        Reset_n = 1'b1;

        // post-reset fill, then every entry reads back INIT_VAL
        count_fill("post_reset", 4);
        for (int i = 0; i < DEPTH; i++) begin
            step("rd_init", 1'b0, 1'b1, 2'(i), 1'b0, 2'd0, 10'h000);
            check("rd_init.const", 32'(Target), 32'h3FF);
        end

        // write then read back
        step("wr1", 1'b0, 1'b0, 2'd0, 1'b1, 2'd1, 10'h003);
        step("rd1", 1'b0, 1'b1, 2'd1, 1'b0, 2'd0, 10'h000);
        check("rd1.const", 32'(Target), 32'h003);
        step("rd2", 1'b0, 1'b1, 2'd2, 1'b0, 2'd0, 10'h000);
        check("rd2.const", 32'(Target), 32'h3FF);

        // same-address read and write: write-first
        step("wf", 1'b0, 1'b1, 2'd2, 1'b1, 2'd2, 10'h007);
        check("wf.const", 32'(Target), 32'h007);

        // different addresses in the same cycle
        step("rw_diff", 1'b0, 1'b1, 2'd1, 1'b1, 2'd0, 10'h155);
        step("rd0", 1'b0, 1'b1, 2'd0, 1'b0, 2'd0, 10'h000);
        check("rd0.const", 32'(Target), 32'h155);

        // write refused during fill, entry restored after fill
        step("init", 1'b1, 1'b0, 2'd0, 1'b0, 2'd0, 10'h000);
        idle("fill0");
        step("wr_fill", 1'b0, 1'b0, 2'd0, 1'b1, 2'd3, 10'h001);
        check("wr_fill.const", 32'(WrErr), 32'd1);
        step("rd_busy", 1'b0, 1'b1, 2'd3, 1'b0, 2'd0, 10'h000);
        check("rd_busy.valid", 32'(Valid), 32'd0);
        check("rd_busy.wrerr", 32'(WrErr), 32'd0);
        count_fill("refill", 1);
        step("rd3", 1'b0, 1'b1, 2'd3, 1'b0, 2'd0, 10'h000);
        check("rd3.const", 32'(Target), 32'h3FF);

        // write refused when issued together with Init in IDLE
        step("wr_init", 1'b1, 1'b1, 2'd0, 1'b1, 2'd0, 10'h011);
        check("wr_init.const", 32'(WrErr), 32'd1);
        count_fill("init_fill", 4);

        // reset in the middle of a fill
        step("pre_rst_wr", 1'b0, 1'b0, 2'd0, 1'b1, 2'd1, 10'h2A5);
        step("pre_rst_rd", 1'b0, 1'b1, 2'd1, 1'b0, 2'd0, 10'h000);
        step("init2", 1'b1, 1'b0, 2'd0, 1'b0, 2'd0, 10'h000);
        idle("fill_a");
        idle("fill_b");
        #2;
        Reset_n = 1'b0;
        #1;
        model_reset();
        check("mid_rst.target", 32'(Target), 32'h0);
        check("mid_rst.valid",  32'(Valid),  32'd0);
        check("mid_rst.busy",   32'(Busy),   32'd1);
        @(negedge Clk);
        Reset_n = 1'b1;
        count_fill("after_rst", 4);

        // randomised traffic
        for (int c = 0; c < 400; c++) begin
            step("rand", ($urandom_range(0, 19) == 0), 1'($urandom), 2'($urandom),
                 1'($urandom), 2'($urandom), 10'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/target_lut_rw.md
TARGET_LUT_RW -- requirements
Module: target_lut_rw

Interface
REQ-001 Parameters, one per line (name, default, meaning):
- ADDR_W, 2, index width; DEPTH = 2**ADDR_W entries.
- TGT_W, 10, target width.
- INIT_VAL, 10'h3FF, value every entry takes during initialisation; TGT_W bits wide.
REQ-002 Ports, one per line (name, direction, width, meaning):
- Clk, input, 1, single clock; all state updates on rising edge.
- Reset_n, input, 1, asynchronous active-low reset.
- Init, input, 1, request re-initialisation of all entries.
- RdEn, input, 1, read request.
- Addr, input, ADDR_W, read index.
- WrEn, input, 1, write request.
- WrAddr, input, ADDR_W, write index.
- WrData, input, TGT_W, write value.
- Target, output, TGT_W, registered read data.
- Valid, output, 1, Target holds the result of the previous cycle's accepted read.
- Busy, output, 1, initialisation in progress; reads and writes are refused.
- WrErr, output, 1, one-cycle pulse when a write is refused.

Function
REQ-003 The table SHALL hold DEPTH registered entries of TGT_W bits.
REQ-004 The FSM SHALL have two states, IDLE and FILL, plus a counter fill_idx of ADDR_W bits.
REQ-005 In FILL, each cycle SHALL write INIT_VAL to entry fill_idx and increment fill_idx. When fill_idx == DEPTH-1, that write SHALL complete and the FSM SHALL return to IDLE on the same edge. FILL lasts exactly DEPTH cycles.
REQ-006 IDLE with Init=1 SHALL go to FILL with fill_idx=0.
REQ-007 Init=1 while in FILL SHALL restart fill_idx at 0.
REQ-008 Busy SHALL be 1 exactly when the state is FILL.
REQ-009 A read SHALL be accepted when RdEn=1, the state is IDLE, and Init=0.
REQ-010 On an accepted read, on the next edge Target SHALL take entry[Addr] and Valid SHALL be 1; latency is 1 cycle.
REQ-011 When no read is accepted, Valid SHALL be 0 on the next cycle and Target SHALL hold its last value.
REQ-012 A write SHALL be accepted when WrEn=1, the state is IDLE, and Init=0. entry[WrAddr] SHALL update on the edge.
REQ-013 Read and accepted write to the same address in the same cycle SHALL be write-first: Target takes WrData.
REQ-014 WrEn=1 while the state is FILL, or while Init=1, SHALL drop the write and pulse WrErr=1 for the next cycle; otherwise WrErr SHALL be 0.
REQ-015 Read and write to different addresses in the same cycle SHALL both complete independently.
REQ-016 Addr and WrAddr SHALL cover all of 0..DEPTH-1; no out-of-range case exists.

Reset
REQ-017 Reset_n=0 SHALL asynchronously force: state=FILL, fill_idx=0, Target=0, Valid=0, WrErr=0, Busy=1.
REQ-018 Table contents SHALL NOT be reset directly; they are defined only after the post-reset FILL completes.
REQ-019 After Reset_n rises, FILL SHALL run for DEPTH cycles, then the FSM enters IDLE.
REQ-020 Reset asserted during FILL or during a read or write SHALL abort it. No partial write SHALL be assumed complete.

Verification (ADDR_W=2, TGT_W=10, INIT_VAL=10'h3FF)
REQ-021 Release reset, hold Init/RdEn/WrEn=0 -> Busy=1 for exactly 4 cycles then 0; then reading Addr=0..3 returns 10'h3FF each, with Valid=1 one cycle after each RdEn.
REQ-022 In IDLE, write WrAddr=1 WrData=10'h003, then read Addr=1 -> Target=10'h003, Valid=1; a read of Addr=2 -> 10'h3FF.
REQ-023 Same cycle RdEn=1 Addr=2 and WrEn=1 WrAddr=2 WrData=10'h007 -> next cycle Target=10'h007.
REQ-024 Pulse Init, then WrEn=1 WrAddr=3 WrData=10'h001 on the second FILL cycle -> WrErr=1 for one cycle; after Busy falls, reading Addr=3 returns 10'h3FF.
REQ-025 RdEn=1 while Busy=1 -> Valid stays 0 and Target unchanged.
REQ-026 Assert Reset_n=0 mid-FILL at fill_idx=2 -> Target=0, Valid=0, Busy=1 immediately; after release, a full 4-cycle FILL runs.
